// File: rtl/barcode_pkg.sv
// barcode_pkg: shared types and constants for the scan-line barcode detector.
//   - row_state_t : per-row decoder state encoding
//   - RUN_W/CNT_W : run-length counter and bar counter widths
//   - within_one  : |a - b| <= 1 helper used by the start-guard check
package barcode_pkg;

    localparam int RUN_W = 10;
    localparam int CNT_W = 6;

    localparam logic [RUN_W-1:0] RUN_MAX         = '1;
    localparam logic [CNT_W-1:0] BAR_MAX         = '1;
    localparam logic [CNT_W-1:0] EXPECT_BARS_DEF = 6'd30;

    typedef enum logic [2:0] {
        S_IDLE,
        S_QUIET,
        S_BAR,
        S_SPACE,
        S_TAIL,
        S_ERR
    } row_state_t;

    function automatic logic within_one(input logic [RUN_W-1:0] a,
                                        input logic [RUN_W-1:0] b);
        return (a >= b) ? ((a - b) <= RUN_W'(1)) : ((b - a) <= RUN_W'(1));
    endfunction

endpackage

// File: rtl/barcode_run_len.sv
// barcode_run_len: run-length front end for the scan-line decoder.
// Ports:
//   clk, rst          : pixel clock, synchronous active-high reset
//   in_de, in_data    : data enable and binarised pixel (1 = black)
//   line_start        : first in_de pixel of a line
//   line_end          : first cycle after in_de falls
//   run_done          : previous run finished this cycle (colour change or line end)
//   run_colour        : colour of the run that just finished
//   run_width         : width of the run that just finished (saturating)
//   cur_width         : width of the run including the current pixel
module barcode_run_len
    import barcode_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_de,
    input  logic             in_data,
    output logic             line_start,
    output logic             line_end,
    output logic             run_done,
    output logic             run_colour,
    output logic [RUN_W-1:0] run_width,
    output logic [RUN_W-1:0] cur_width
);

    logic             de_d;
    logic             colour_q;
    logic [RUN_W-1:0] width_q;
    logic             colour_chg;

    assign line_start = in_de & ~de_d;
    assign line_end   = ~in_de & de_d;
    assign colour_chg = in_de & de_d & (in_data != colour_q);
    assign run_done   = colour_chg | line_end;
    assign run_colour = colour_q;
    assign run_width  = width_q;

    always_comb begin
        cur_width = width_q;
        if (in_de) begin
            if (line_start || colour_chg) begin
                cur_width = RUN_W'(1);
            end else if (width_q != RUN_MAX) begin
                cur_width = width_q + 1'b1;
            end
        end
    end

    // de_d resets high so a reset released mid-line never looks like a line
    // start; the remainder of that line is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            de_d     <= 1'b1;
            colour_q <= 1'b0;
            width_q  <= '0;
        end else begin
            de_d <= in_de;
            if (in_de) begin
                colour_q <= in_data;
                width_q  <= cur_width;
            end
        end
    end

endmodule

// File: rtl/barcode_scan.sv
// barcode_scan: scan-line barcode detector producing the overlay's scan_en.
// Build option: define BARCODE_GUARD_CHECK_EN to check the start guard
// (bar/space/bar widths within one pixel of the first bar) and report the
// module width; otherwise mod_width is tied to zero.
// Ports:
//   clk, rst            : pixel clock, synchronous active-high reset
//   x_in, y_in          : pixel coordinates (x is informational only)
//   in_vs, in_de        : vertical sync, data enable
//   in_data             : binarised pixel, 1 = black
//   scan_en             : all three rows decoded valid in the previous frame
//   bar_cnt             : bar count of the most recently finished row
//   mod_width           : start-guard bar width of the last valid row
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for the first pixel of a scan row
// S_QUIET | inside the leading white quiet zone
// S_BAR   | measuring a black bar
// S_SPACE | measuring a white space between bars
// S_TAIL  | symbol closed by a wide space; only white may follow
// S_ERR   | row rejected, waiting for line end
module barcode_scan
    import barcode_pkg::*;
#(
    parameter logic [RUN_W-1:0] BAR_LOC_Y1  = 10'd80,
    parameter logic [RUN_W-1:0] BAR_LOC_Y2  = 10'd100,
    parameter logic [RUN_W-1:0] BAR_LOC_Y3  = 10'd130,
    parameter logic [CNT_W-1:0] EXPECT_BARS = EXPECT_BARS_DEF,
    parameter logic [RUN_W-1:0] MIN_W       = 10'd1,
    parameter logic [RUN_W-1:0] MAX_W       = 10'd16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [RUN_W-1:0] x_in,
    input  logic [RUN_W-1:0] y_in,
    input  logic             in_vs,
    input  logic             in_de,
    input  logic             in_data,
    output logic             scan_en,
    output logic [CNT_W-1:0] bar_cnt,
    output logic [CNT_W-1:0] mod_width
);

    logic             line_start;
    logic             line_end;
    logic             run_done;
    logic             run_colour;
    logic [RUN_W-1:0] run_width;
    logic [RUN_W-1:0] cur_width;

    barcode_run_len u_run_len (
        .clk        (clk),
        .rst        (rst),
        .in_de      (in_de),
        .in_data    (in_data),
        .line_start (line_start),
        .line_end   (line_end),
        .run_done   (run_done),
        .run_colour (run_colour),
        .run_width  (run_width),
        .cur_width  (cur_width)
    );

    logic unused_x;
    assign unused_x = ^x_in;

    row_state_t       state_q, state_nx;
    logic [2:0]       row_sel_q, row_sel_nx;
    logic [CNT_W-1:0] bars_q, bars_nx;
    logic [2:0]       row_ok;
    logic             vs_d;
    logic             vs_rise;
    logic [2:0]       hit_sel;
    logic             bar_end;
    logic             space_end;
    logic             guard_bad;
    logic             line_fin;
    logic             line_good;

    assign vs_rise   = in_vs & ~vs_d;
    assign bar_end   = run_done & in_de & run_colour;
    assign space_end = run_done & in_de & ~run_colour;

`ifdef BARCODE_GUARD_CHECK_EN
    logic [RUN_W-1:0] w0_q, w0_nx;
    // With one bar counted, the run now ending is either the first space
    // or the second bar; both must match the first bar within one pixel.
    assign guard_bad = (bars_q == CNT_W'(1)) && !within_one(run_width, w0_q);
`else
    assign guard_bad = 1'b0;
`endif

    always_comb begin
        hit_sel = 3'b000;
        if (y_in == BAR_LOC_Y1) begin
            hit_sel = 3'b001;
        end else if (y_in == BAR_LOC_Y2) begin
            hit_sel = 3'b010;
        end else if (y_in == BAR_LOC_Y3) begin
            hit_sel = 3'b100;
        end
    end

    always_comb begin
        state_nx   = state_q;
        row_sel_nx = row_sel_q;
        bars_nx    = bars_q;
        line_fin   = 1'b0;
        line_good  = 1'b0;
`ifdef BARCODE_GUARD_CHECK_EN
        w0_nx      = w0_q;
`endif
        if (vs_rise) begin
            // Aborted rows need no explicit clear: row_ok is wiped on vs_rise.
            state_nx = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (line_start && (hit_sel != 3'b000)) begin
                        row_sel_nx = hit_sel;
                        bars_nx    = '0;
`ifdef BARCODE_GUARD_CHECK_EN
                        w0_nx      = '0;
`endif
                        // A black first pixel means the symbol is clipped.
                        state_nx   = in_data ? S_ERR : S_QUIET;
                    end
                end
                S_QUIET: begin
                    if (line_end) begin
                        line_fin  = 1'b1;
                        line_good = (bars_q == EXPECT_BARS);
                        state_nx  = S_IDLE;
                    end else if (in_de && in_data) begin
                        state_nx = S_BAR;
                    end
                end
                S_BAR: begin
                    if (line_end) begin
                        line_fin = 1'b1;
                        state_nx = S_IDLE;
                    end else if (bar_end) begin
                        if ((run_width > MAX_W) || (run_width < MIN_W) || guard_bad) begin
                            state_nx = S_ERR;
                        end else begin
                            bars_nx  = (bars_q == BAR_MAX) ? bars_q : bars_q + 1'b1;
`ifdef BARCODE_GUARD_CHECK_EN
                            if (bars_q == '0) begin
                                w0_nx = run_width;
                            end
`endif
                            state_nx = S_SPACE;
                        end
                    end
                end
                S_SPACE: begin
                    if (line_end) begin
                        line_fin  = 1'b1;
                        line_good = (bars_q == EXPECT_BARS);
                        state_nx  = S_IDLE;
                    end else if (space_end) begin
                        state_nx = ((run_width < MIN_W) || guard_bad) ? S_ERR : S_BAR;
                    end else if (in_de && (cur_width > MAX_W)) begin
                        state_nx = S_TAIL;
                    end
                end
                S_TAIL: begin
                    if (line_end) begin
                        line_fin  = 1'b1;
                        line_good = (bars_q == EXPECT_BARS);
                        state_nx  = S_IDLE;
                    end else if (in_de && in_data) begin
                        state_nx = S_ERR;
                    end
                end
                S_ERR: begin
                    if (line_end) begin
                        line_fin = 1'b1;
                        state_nx = S_IDLE;
                    end
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            row_sel_q <= '0;
            bars_q    <= '0;
            row_ok    <= '0;
            vs_d      <= 1'b0;
            scan_en   <= 1'b0;
            bar_cnt   <= '0;
        end else begin
            state_q   <= state_nx;
            row_sel_q <= row_sel_nx;
            bars_q    <= bars_nx;
            vs_d      <= in_vs;
            if (vs_rise) begin
                scan_en <= &row_ok;
                row_ok  <= '0;
            end else if (line_fin) begin
                row_ok  <= line_good ? (row_ok | row_sel_q) : (row_ok & ~row_sel_q);
                bar_cnt <= bars_q;
            end
        end
    end

`ifdef BARCODE_GUARD_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            w0_q      <= '0;
            mod_width <= '0;
        end else begin
            w0_q <= w0_nx;
            if (!vs_rise && line_fin && line_good) begin
                mod_width <= w0_q[CNT_W-1:0];
            end
        end
    end
`else
    assign mod_width = '0;
`endif

endmodule
